// File: rtl/solver_sample_capture.sv
// solver_sample_capture: periodically samples the RK4 solver outputs {w, i} into a
// first-word-fall-through FIFO and streams them out on a valid/ready interface.
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   enable        - capture enable; when low the tick counter is held at 0
//   decim         - sample period in clocks (0 behaves as 1)
//   i_in, w_in    - solver current and speed (float32, free-running, no strobe)
//   m_tdata       - {w, i} of the FIFO head
//   m_tvalid      - FIFO non-empty
//   m_tready      - consumer accepts the head word
//   level         - FIFO occupancy, 0..DEPTH
//   overflow_cnt  - saturating count of samples dropped because the FIFO was full
//   clear_ovf     - synchronous clear of overflow_cnt (wins over an increment)
module solver_sample_capture #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned OVF_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [CNT_W-1:0]         decim,
  input  logic [31:0]              i_in,
  input  logic [31:0]              w_in,
  output logic [63:0]              m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [OVF_W-1:0]         overflow_cnt,
  input  logic                     clear_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic [63:0]      tdata_q, tdata_d;
  logic [63:0]      mem_q [DEPTH];

  logic [CNT_W-1:0] period_m1;
  logic             strobe;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;
  logic             drop;
  logic [63:0]      wdata;
  logic [63:0]      head_d;

  // Tick counter and capture strobe.
  always_comb begin
    period_m1 = (decim == '0) ? '0 : decim - CNT_W'(1);
    // ">=" rather than "==" so that lowering decim below the count fires on the next clock.
    strobe    = enable && (cnt_q >= period_m1);
    cnt_d     = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (strobe) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // FIFO control.
  always_comb begin
    full     = (level_q == LW'(DEPTH));
    empty    = (level_q == '0);
    pop      = !empty && m_tready;
    push     = strobe && (!full || pop);
    drop     = strobe && full && !pop;
    wdata    = {w_in, i_in};

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end

    // Next head word: the word being written becomes the head only when it lands on the
    // slot the read pointer will point at (FIFO empty after this edge apart from it).
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wdata;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
    // When the FIFO goes empty, hold the last presented word.
    tdata_d = (level_d != '0) ? head_d : tdata_q;
  end

  // Saturating overflow counter; clear wins over a same-cycle drop.
  always_comb begin
    ovf_d = ovf_q;
    if (clear_ovf) begin
      ovf_d = '0;
    end else if (drop && !(&ovf_q)) begin
      ovf_d = ovf_q + OVF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
      tdata_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      tdata_q  <= tdata_d;
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign m_tdata      = tdata_q;
  assign m_tvalid     = (level_q != '0);
  assign level        = level_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: doc/solver_sample_capture.md
Name: solver_sample_capture

Overview:
- Downstream consumer of the RK4 motor-model solver outputs: current `i` and speed `w`, both IEEE-754 single, updated continuously with no strobe.
- Samples the {w, i} pair every `decim` clocks, while enabled, into a first-word-fall-through FIFO.
- Presents samples on a valid/ready stream to the DMA/AXI side for logging.
- Counts samples dropped on FIFO overflow.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CNT_W, 32, width of the decimation counter and of `decim`.
- OVF_W, 16, width of the overflow counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- enable  input  1  capture enable
- decim  input  CNT_W  sample period in clocks; 0 treated as 1
- i_in  input  32  solver current, float32
- w_in  input  32  solver speed, float32
- m_tdata  output  64  {w[63:32], i[31:0]} of the FIFO head
- m_tvalid  output  1  FIFO non-empty
- m_tready  input  1  consumer accepts head
- level  output  $clog2(DEPTH)+1  current FIFO occupancy
- overflow_cnt  output  OVF_W  dropped-sample count, saturating
- clear_ovf  input  1  synchronous clear of overflow_cnt

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: m_tvalid=0, m_tdata=0, level=0, overflow_cnt=0, tick counter=0, FIFO pointers=0.
  - Reset mid-operation discards all FIFO contents in the same edge.
- Tick counter:
  - `enable`=0: held at 0, no capture.
  - `enable`=1: increments each clock.
  - Capture strobe asserts when counter >= eff_decim-1, where eff_decim = max(decim,1). Counter returns to 0 on that same clock.
  - First capture occurs on the eff_decim-th clock with enable high. decim=1 captures every clock.
  - If `decim` is lowered below the current count, capture occurs on the next clock.
- Capture: on the strobe clock, {w_in, i_in} is the word written; the input values present on that clock are the ones stored.
- Push/pop:
  - pop = m_tvalid & m_tready.
  - push = strobe & (!full | pop).
  - Full with a simultaneous pop: both happen; level is unchanged.
  - Full without pop: sample dropped; overflow_cnt increments, saturating at 2^OVF_W-1.
  - Empty: push only, since m_tvalid=0. Word appears on m_tdata with m_tvalid=1 on the clock after the strobe (1-cycle latency).
- Stream output:
  - FWFT: m_tdata always equals the head entry while m_tvalid=1.
  - m_tdata is stable while m_tvalid=1 and m_tready=0.
  - When empty, m_tdata holds its last value; the value is don't-care for checking.
- level: +1 on push-only, -1 on pop-only, unchanged otherwise. Range 0..DEPTH. full = level==DEPTH; empty = level==0.
- Pointers: wrap modulo DEPTH.
- clear_ovf: zeroes overflow_cnt. It has priority over a same-cycle overflow increment.
- Dropping enable: stops new captures only. Queued data remains readable.

Test Plan:
1. Reset and first sample:
   - Stimulus: rst for 2 clocks, then enable=1, decim=4, i_in=32'h3f800000, w_in=32'h40000000, m_tready=0.
   - Required: first strobe on the 4th enabled clock; m_tvalid=1 one clock later; m_tdata=64'h40000000_3f800000; level=1.
2. Fill and overflow:
   - Stimulus: decim=1, m_tready=0, for 20 clocks.
   - Required: level saturates at 16; overflow_cnt=4 for DEPTH=16; the stored entries are the first 16 captured values, in order.
3. Full with simultaneous pop:
   - Stimulus: FIFO full, decim=1, m_tready=1 for 8 clocks.
   - Required: level stays 16, overflow_cnt unchanged, popped words arrive in capture order with no gaps.
4. decim=0 and decim change:
   - Stimulus: decim=0 (behaves as 1), then switch decim from 100 to 3 while the count is at 50.
   - Required: decim=0 captures every clock; after the switch, capture on the next clock, then every 3 clocks.
5. Backpressure stability:
   - Stimulus: toggle m_tready pseudo-randomly while ramping i_in.
   - Required: m_tdata stable whenever m_tvalid=1 and m_tready=0; received sequence equals the captured sequence.
6. Reset mid-operation and clear priority:
   - Stimulus: rst with level=9 and overflow_cnt=3; separately, clear_ovf coincident with an overflow.
   - Required: the reset leaves level=0, m_tvalid=0, overflow_cnt=0 on the next clock; clear_ovf coincident with the overflow leaves overflow_cnt=0.
